// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states,
// frame geometry and parity-sense constants.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    localparam int DATA_MAX = 8;
    localparam int SHREG_W  = 10;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Data plus parity bits sampled after the start bit
    function automatic logic [3:0] frame_bits(
        input logic eight,
        input logic pen
    );
        return 4'd7 + 4'(eight) + 4'(pen);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-time down-counter; tick marks
// the last clock of the loaded interval.
module uart_bit_timer #(
    parameter int DIV_W = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // Reload on request, otherwise run down to zero and stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - DIV_W'(1);
        end
    end

    assign tick = (cnt == DIV_W'(1));

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronizes rx, samples mid-bit,
// checks parity and stop, and flags overruns to the host.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int DIV_W = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    input  logic [DIV_W-1:0] baud_k,
    input  logic             eight,
    input  logic             pen,
    input  logic             ohel,
    input  logic             read,
    output logic [7:0]       rx_data,
    output logic             rx_rdy,
    output logic             perr,
    output logic             ferr,
    output logic             ovf
);

    logic rx_m;
    logic rx_s;

    rx_state_t state;

    logic             eight_l;
    logic             pen_l;
    logic             ohel_l;
    logic [DIV_W-1:0] k_l;

    logic [3:0]         bit_cnt;
    logic [SHREG_W-1:0] shreg;

    logic             tmr_load;
    logic [DIV_W-1:0] tmr_val;
    logic             tick;

    logic [3:0]         n_bits;
    logic [SHREG_W-1:0] just;
    logic [7:0]         data_x;
    logic               par_x;
    logic               perr_x;

    // Two-flop synchronizer, idles high out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    uart_bit_timer #(
        .DIV_W(DIV_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .load_val(tmr_val),
        .tick    (tick)
    );

    // Half-bit delay to the start sample, full bits after
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = k_l;
        unique case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    tmr_load = 1'b1;
                    tmr_val  = baud_k >> 1;
                end
            end
            ST_START: begin
                if (tick && !rx_s) begin
                    tmr_load = 1'b1;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    tmr_load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Right-justify the sampled bits and evaluate parity
    always_comb begin
        n_bits = frame_bits(eight_l, pen_l);
        just   = shreg >> (4'(SHREG_W) - n_bits);
        data_x = just[7:0];
        if (!eight_l) begin
            data_x[7] = 1'b0;
        end
        par_x  = just[4'd7 + 4'(eight_l)];
        perr_x = pen_l & ((^data_x ^ par_x) != ohel_l);
    end

    // Frame sequencing, shift register and host flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            eight_l <= 1'b0;
            pen_l   <= 1'b0;
            ohel_l  <= PAR_EVEN;
            k_l     <= '0;
            bit_cnt <= '0;
            shreg   <= '1;
            rx_data <= '0;
            rx_rdy  <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (read) begin
                rx_rdy <= 1'b0;
                perr   <= 1'b0;
                ferr   <= 1'b0;
                ovf    <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        eight_l <= eight;
                        pen_l   <= pen;
                        ohel_l  <= ohel;
                        k_l     <= baud_k;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else begin
                            bit_cnt <= '0;
                            state   <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shreg   <= {rx_s, shreg[SHREG_W-1:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == n_bits - 4'd1) begin
                            state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        rx_data <= data_x;
                        perr    <= perr_x;
                        ferr    <= ~rx_s;
                        ovf     <= ~read & (rx_rdy | ovf);
                        rx_rdy  <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
